// File: rtl/mem_arb36.sv
// Three-port arbiter sharing one 36-bit Avalon-MM slave: two core memory ports
// with 16-bit word addresses relocated by BASE_Px, plus a full-width console port.
module mem_arb36 #(
  parameter logic [1:0]  BASE_P0      = 2'd0,
  parameter logic [1:0]  BASE_P1      = 2'd1,
  parameter bit          CONSOLE_PRIO = 1'b1,
  parameter logic [15:0] TIMEOUT      = 16'd1000
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic [17:0] s0_address,
  input  logic        s0_read,
  input  logic        s0_write,
  input  logic [35:0] s0_writedata,
  output logic [35:0] s0_readdata,
  output logic        s0_waitrequest,

  input  logic [17:0] s1_address,
  input  logic        s1_read,
  input  logic        s1_write,
  input  logic [35:0] s1_writedata,
  output logic [35:0] s1_readdata,
  output logic        s1_waitrequest,

  input  logic [17:0] s2_address,
  input  logic        s2_read,
  input  logic        s2_write,
  input  logic [35:0] s2_writedata,
  output logic [35:0] s2_readdata,
  output logic        s2_waitrequest,

  output logic [17:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [35:0] m_writedata,
  input  logic [35:0] m_readdata,
  input  logic        m_waitrequest,

  output logic        err_timeout,
  output logic        err_proto,
  input  logic        err_clr
);

  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_owner;
  logic [1:0]  w_owner_next;
  logic [1:0]  r_rr;
  logic [1:0]  w_rr_next;
  logic [15:0] r_wdog;
  logic        r_err_timeout;
  logic        r_err_proto;

  logic [2:0]  w_rd;
  logic [2:0]  w_wr;
  logic [2:0]  w_req;
  logic [17:0] w_addr  [3];
  logic [35:0] w_wdata [3];

  logic [1:0]  w_pick;
  logic        w_any;
  logic        w_own_req;
  logic        w_done;
  logic        w_timeout;
  logic        w_abort;
  logic        w_set_proto;

  logic [2:0]  w_wait_o;
  logic [35:0] w_rdata_o [3];

  // Upper address bits of the core ports are replaced by the relocation base.
  logic        w_unused_addr_hi;
  assign w_unused_addr_hi = ^{s0_address[17:16], s1_address[17:16]};

  assign w_rd  = {s2_read,  s1_read,  s0_read};
  assign w_wr  = {s2_write, s1_write, s0_write};
  assign w_req = w_rd | w_wr;

  assign w_addr[0]  = {BASE_P0, s0_address[15:0]};
  assign w_addr[1]  = {BASE_P1, s1_address[15:0]};
  assign w_addr[2]  = s2_address;
  assign w_wdata[0] = s0_writedata;
  assign w_wdata[1] = s1_writedata;
  assign w_wdata[2] = s2_writedata;

  assign w_own_req   = w_req[r_owner];
  assign w_done      = (r_state == ST_GRANT) && w_own_req && !m_waitrequest;
  assign w_timeout   = (TIMEOUT != 16'd0) && (r_state == ST_GRANT) && (r_wdog == TIMEOUT);
  // A completion landing on the watchdog cycle is honoured rather than aborted.
  assign w_abort     = w_timeout && !w_done;
  assign w_set_proto = (r_state == ST_GRANT) && w_rd[r_owner] && w_wr[r_owner];

  // Winner selection, only consulted while IDLE.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    int         sum;
    w_pick = 2'd0;
    w_any  = |w_req;
    found  = 1'b0;
    idx    = 2'd0;
    sum    = 0;
    if (CONSOLE_PRIO) begin
      if (w_req[2]) begin
        w_pick = 2'd2;
      end else if (w_req[0] && w_req[1]) begin
        w_pick = (r_rr == 2'd0) ? 2'd1 : 2'd0;
      end else if (w_req[1]) begin
        w_pick = 2'd1;
      end else begin
        w_pick = 2'd0;
      end
    end else begin
      for (int i = 1; i <= 3; i++) begin
        sum = int'(r_rr) + i;
        if (sum >= 3) begin
          sum = sum - 3;
        end
        idx = 2'(sum);
        if (!found && w_req[idx]) begin
          w_pick = idx;
          found  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_owner <= 2'd0;
      r_rr    <= 2'd2;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_rr    <= w_rr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_rr_next    = r_rr;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_next = ST_GRANT;
          w_owner_next = w_pick;
          w_rr_next    = w_pick;
        end
      end
      ST_GRANT: begin
        // A request dropped mid-transaction simply releases the slave.
        if (w_done || w_abort || !w_own_req) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_address   = 18'd0;
    m_writedata = 36'd0;
    w_wait_o    = 3'b111;
    for (int i = 0; i < 3; i++) begin
      w_rdata_o[i] = 36'd0;
    end
    if (r_state == ST_GRANT) begin
      m_address   = w_addr[r_owner];
      m_writedata = w_wdata[r_owner];
      if (w_abort) begin
        w_wait_o[r_owner] = 1'b0;
      end else begin
        m_read               = w_rd[r_owner] && !w_wr[r_owner];
        m_write              = w_wr[r_owner];
        w_wait_o[r_owner]    = m_waitrequest;
        w_rdata_o[r_owner]   = m_readdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= 16'd0;
    end else if (r_state == ST_GRANT) begin
      r_wdog <= r_wdog + 16'd1;
    end else begin
      r_wdog <= 16'd0;
    end
  end

  // Sticky error flags; a set event outranks a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_timeout <= 1'b0;
      r_err_proto   <= 1'b0;
    end else begin
      if (w_abort) begin
        r_err_timeout <= 1'b1;
      end else if (err_clr) begin
        r_err_timeout <= 1'b0;
      end
      if (w_set_proto) begin
        r_err_proto <= 1'b1;
      end else if (err_clr) begin
        r_err_proto <= 1'b0;
      end
    end
  end

  assign s0_waitrequest = w_wait_o[0];
  assign s1_waitrequest = w_wait_o[1];
  assign s2_waitrequest = w_wait_o[2];
  assign s0_readdata    = w_rdata_o[0];
  assign s1_readdata    = w_rdata_o[1];
  assign s2_readdata    = w_rdata_o[2];
  assign err_timeout    = r_err_timeout;
  assign err_proto      = r_err_proto;

endmodule

// File: tb/tb_mem_arb36.sv
// Directed bench for mem_arb36: one priority-mode and one round-robin-mode instance
// share stimulus; cycle vectors come from a table, watchdog/error/reset cases are hand-written.
module tb_mem_arb36;

  localparam logic [15:0] A0  = 16'h0123;
  localparam logic [15:0] A1  = 16'h0789;
  localparam logic [17:0] A2  = 18'h3ABCD;
  localparam logic [35:0] WD0 = 36'h123450A0A;
  localparam logic [35:0] WD1 = 36'h2468A0B0B;
  localparam logic [35:0] WD2 = 36'h3CAFE0C0C;
  localparam logic [35:0] MR  = 36'o123456701234;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [17:0] s0_address, s1_address, s2_address;
  logic        s0_read, s0_write, s1_read, s1_write, s2_read, s2_write;
  logic [35:0] s0_writedata, s1_writedata, s2_writedata;
  logic [35:0] m_readdata;
  logic        m_waitrequest;
  logic        err_clr;

  logic [35:0] s0_readdata, s1_readdata, s2_readdata;
  logic        s0_waitrequest, s1_waitrequest, s2_waitrequest;
  logic [17:0] m_address;
  logic        m_read, m_write;
  logic [35:0] m_writedata;
  logic        err_timeout, err_proto;

  logic [35:0] rr_s0_readdata, rr_s1_readdata, rr_s2_readdata;
  logic        rr_s0_waitrequest, rr_s1_waitrequest, rr_s2_waitrequest;
  logic [17:0] rr_m_address;
  logic        rr_m_read, rr_m_write;
  logic [35:0] rr_m_writedata;
  logic        rr_err_timeout, rr_err_proto;

  mem_arb36 #(.BASE_P0(2'd0), .BASE_P1(2'd1), .CONSOLE_PRIO(1'b1), .TIMEOUT(16'd8)) dut (
    .clk(clk), .reset_n(reset_n),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_readdata(s0_readdata), .s0_waitrequest(s0_waitrequest),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_readdata(s1_readdata), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_read(s2_read), .s2_write(s2_write),
    .s2_writedata(s2_writedata), .s2_readdata(s2_readdata), .s2_waitrequest(s2_waitrequest),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .err_timeout(err_timeout), .err_proto(err_proto), .err_clr(err_clr)
  );

  mem_arb36 #(.BASE_P0(2'd0), .BASE_P1(2'd1), .CONSOLE_PRIO(1'b0), .TIMEOUT(16'd8)) dut_rr (
    .clk(clk), .reset_n(reset_n),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_readdata(rr_s0_readdata), .s0_waitrequest(rr_s0_waitrequest),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_readdata(rr_s1_readdata), .s1_waitrequest(rr_s1_waitrequest),
    .s2_address(s2_address), .s2_read(s2_read), .s2_write(s2_write),
    .s2_writedata(s2_writedata), .s2_readdata(rr_s2_readdata), .s2_waitrequest(rr_s2_waitrequest),
    .m_address(rr_m_address), .m_read(rr_m_read), .m_write(rr_m_write), .m_writedata(rr_m_writedata),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
    .err_timeout(rr_err_timeout), .err_proto(rr_err_proto), .err_clr(err_clr)
  );

  typedef struct {
    logic        inst;    // 0 = priority instance, 1 = round-robin instance
    logic        adv;     // advance one clock after checking
    logic        rst;     // pulse reset before applying
    logic [2:0]  rd;
    logic [2:0]  wr;
    logic        mwait;
    logic        e_rd;
    logic        e_wr;
    logic [17:0] e_addr;
    logic [2:0]  e_wait;
    logic [1:0]  e_wsel;  // 3 = m_writedata expected zero
    logic [2:0]  e_rmask; // ports expected to see m_readdata
    logic        e_eto;
    logic        e_ep;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic inst, input logic adv, input logic rst,
                              input logic [2:0] rd, input logic [2:0] wr, input logic mw,
                              input logic er, input logic ew, input logic [17:0] ea,
                              input logic [2:0] ewt, input logic [1:0] ws,
                              input logic [2:0] rm, input logic eto, input logic ep);
    vec_t v;
    v.inst = inst; v.adv = adv; v.rst = rst; v.rd = rd; v.wr = wr; v.mwait = mw;
    v.e_rd = er; v.e_wr = ew; v.e_addr = ea; v.e_wait = ewt; v.e_wsel = ws;
    v.e_rmask = rm; v.e_eto = eto; v.e_ep = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0; s2_read = 0; s2_write = 0;
    s0_address = {2'b11, A0}; s1_address = {2'b10, A1}; s2_address = A2;
    s0_writedata = WD0; s1_writedata = WD1; s2_writedata = WD2;
    m_readdata = MR; m_waitrequest = 1'b1; err_clr = 1'b0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [24:0]  a_ctl, e_ctl;
    logic [35:0]  a_wd, e_wd;
    logic [107:0] a_rd, e_rd;
    vec_t v;

    clear_inputs();
    reset_n = 1'b0;

    // Port-0 read with two slave wait cycles.
    vq.push_back(mk(0,1,1, 3'b000,3'b000,1, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    vq.push_back(mk(0,1,0, 3'b001,3'b000,1, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    vq.push_back(mk(0,1,0, 3'b001,3'b000,1, 1,0,18'h00123,3'b111,2'd0,3'b001,0,0));
    vq.push_back(mk(0,1,0, 3'b001,3'b000,1, 1,0,18'h00123,3'b111,2'd0,3'b001,0,0));
    vq.push_back(mk(0,1,0, 3'b001,3'b000,0, 1,0,18'h00123,3'b110,2'd0,3'b001,0,0));
    vq.push_back(mk(0,1,0, 3'b000,3'b000,1, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    // Ports 0 and 1 writing continuously alternate.
    vq.push_back(mk(0,1,1, 3'b000,3'b011,0, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    vq.push_back(mk(0,1,0, 3'b000,3'b011,0, 0,1,18'h00123,3'b110,2'd0,3'b001,0,0));
    vq.push_back(mk(0,1,0, 3'b000,3'b011,0, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    vq.push_back(mk(0,1,0, 3'b000,3'b011,0, 0,1,18'h10789,3'b101,2'd1,3'b010,0,0));
    vq.push_back(mk(0,1,0, 3'b000,3'b011,0, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    vq.push_back(mk(0,1,0, 3'b000,3'b011,0, 0,1,18'h00123,3'b110,2'd0,3'b001,0,0));
    vq.push_back(mk(0,1,0, 3'b000,3'b011,0, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    vq.push_back(mk(0,1,0, 3'b000,3'b011,0, 0,1,18'h10789,3'b101,2'd1,3'b010,0,0));
    // Console arrives during a port-0 grant: priority vs round-robin order.
    vq.push_back(mk(0,0,1, 3'b001,3'b000,1, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    vq.push_back(mk(1,1,0, 3'b001,3'b000,1, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    vq.push_back(mk(0,0,0, 3'b111,3'b000,1, 1,0,18'h00123,3'b111,2'd0,3'b001,0,0));
    vq.push_back(mk(1,1,0, 3'b111,3'b000,1, 1,0,18'h00123,3'b111,2'd0,3'b001,0,0));
    vq.push_back(mk(0,0,0, 3'b111,3'b000,0, 1,0,18'h00123,3'b110,2'd0,3'b001,0,0));
    vq.push_back(mk(1,1,0, 3'b111,3'b000,0, 1,0,18'h00123,3'b110,2'd0,3'b001,0,0));
    vq.push_back(mk(0,0,0, 3'b110,3'b000,1, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    vq.push_back(mk(1,1,0, 3'b110,3'b000,1, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    vq.push_back(mk(0,0,0, 3'b110,3'b000,0, 1,0,18'h3ABCD,3'b011,2'd2,3'b100,0,0));
    vq.push_back(mk(1,1,0, 3'b110,3'b000,0, 1,0,18'h10789,3'b101,2'd1,3'b010,0,0));
    vq.push_back(mk(0,0,0, 3'b110,3'b000,1, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    vq.push_back(mk(1,1,0, 3'b110,3'b000,1, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    vq.push_back(mk(0,0,0, 3'b110,3'b000,0, 1,0,18'h3ABCD,3'b011,2'd2,3'b100,0,0));
    vq.push_back(mk(1,1,0, 3'b110,3'b000,0, 1,0,18'h3ABCD,3'b011,2'd2,3'b100,0,0));
    vq.push_back(mk(0,0,0, 3'b010,3'b000,1, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    vq.push_back(mk(1,1,0, 3'b010,3'b000,1, 0,0,18'h00000,3'b111,2'd3,3'b000,0,0));
    vq.push_back(mk(0,0,0, 3'b010,3'b000,0, 1,0,18'h10789,3'b101,2'd1,3'b010,0,0));
    vq.push_back(mk(1,1,0, 3'b010,3'b000,0, 1,0,18'h10789,3'b101,2'd1,3'b010,0,0));

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vq[i]) begin
      v = vq[i];
      if (v.rst) pulse_reset();
      {s2_read, s1_read, s0_read}    = v.rd;
      {s2_write, s1_write, s0_write} = v.wr;
      m_waitrequest = v.mwait;
      #1;
      if (v.inst) begin
        a_ctl = {rr_m_read, rr_m_write, rr_m_address,
                 rr_s2_waitrequest, rr_s1_waitrequest, rr_s0_waitrequest, rr_err_timeout, rr_err_proto};
        a_wd  = rr_m_writedata;
        a_rd  = {rr_s2_readdata, rr_s1_readdata, rr_s0_readdata};
      end else begin
        a_ctl = {m_read, m_write, m_address,
                 s2_waitrequest, s1_waitrequest, s0_waitrequest, err_timeout, err_proto};
        a_wd  = m_writedata;
        a_rd  = {s2_readdata, s1_readdata, s0_readdata};
      end
      e_ctl = {v.e_rd, v.e_wr, v.e_addr, v.e_wait, v.e_eto, v.e_ep};
      case (v.e_wsel)
        2'd0:    e_wd = WD0;
        2'd1:    e_wd = WD1;
        2'd2:    e_wd = WD2;
        default: e_wd = 36'd0;
      endcase
      e_rd = {v.e_rmask[2] ? MR : 36'd0, v.e_rmask[1] ? MR : 36'd0, v.e_rmask[0] ? MR : 36'd0};
      $display("vec %0d inst=%0d rd=%b wr=%b mwait=%b -> m_addr=%h rd/wr=%b%b wait=%b",
               i, v.inst, v.rd, v.wr, v.mwait, a_ctl[22:5], a_ctl[24], a_ctl[23], a_ctl[4:2]);
      chk($sformatf("vec%0d_ctl", i), 128'(a_ctl), 128'(e_ctl));
      chk($sformatf("vec%0d_wdata", i), 128'(a_wd), 128'(e_wd));
      chk($sformatf("vec%0d_rdata", i), 128'(a_rd), 128'(e_rd));
      if (v.adv) @(negedge clk);
    end

    // Watchdog: slave stalls forever, abort after 8 GRANT cycles.
    @(negedge clk);
    pulse_reset();
    m_readdata = '1;
    s0_read = 1'b1;
    #1;
    chk("to_idle_wait", 128'(s0_waitrequest), 128'(1'b1));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      chk($sformatf("to_hold%0d", k), 128'({m_read, s0_waitrequest}), 128'(2'b11));
    end
    @(negedge clk); #1;
    $display("timeout cycle: s0_waitrequest=%b s0_readdata=%h m_read=%b", s0_waitrequest, s0_readdata, m_read);
    chk("to_abort_ctl", 128'({m_read, m_write, s0_waitrequest, err_timeout}), 128'(4'b0000));
    chk("to_abort_rdata", 128'(s0_readdata), 128'(36'd0));
    @(negedge clk);
    s0_read = 1'b0;
    #1;
    chk("to_flag", 128'({err_timeout, s0_waitrequest}), 128'(2'b11));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("to_clr", 128'(err_timeout), 128'(1'b0));

    // Completion on the watchdog cycle wins; no flag.
    @(negedge clk);
    pulse_reset();
    s0_read = 1'b1;
    for (int k = 0; k < 9; k++) @(negedge clk);
    m_waitrequest = 1'b0;
    #1;
    chk("to_done_ctl", 128'({m_read, s0_waitrequest}), 128'(2'b10));
    chk("to_done_rdata", 128'(s0_readdata), 128'(MR));
    @(negedge clk);
    s0_read = 1'b0;
    m_waitrequest = 1'b1;
    #1;
    chk("to_done_noflag", 128'(err_timeout), 128'(1'b0));

    // Read+write together on port 1, then asynchronous reset mid-GRANT.
    @(negedge clk);
    pulse_reset();
    s1_read = 1'b1; s1_write = 1'b1;
    #1;
    chk("pr_idle", 128'({m_read, m_write, s1_waitrequest}), 128'(3'b001));
    @(negedge clk); #1;
    $display("proto cycle: m_read=%b m_write=%b m_address=%h err_proto=%b", m_read, m_write, m_address, err_proto);
    chk("pr_cmd", 128'({m_read, m_write, m_address, err_proto}), 128'({1'b0, 1'b1, 18'h10789, 1'b0}));
    chk("pr_wdata", 128'(m_writedata), 128'(WD1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("pr_flag_set_wins", 128'({err_proto, m_write}), 128'(2'b11));
    reset_n = 1'b0;
    #1;
    chk("rst_mid_grant", 128'({m_read, m_write, s2_waitrequest, s1_waitrequest, s0_waitrequest, err_proto}),
        128'(6'b001110));
    chk("rst_mid_addr", 128'({m_address, s1_readdata}), 128'(54'd0));
    reset_n = 1'b1;
    clear_inputs();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arb36.md
Name: mem_arb36

Overview:
- Three-port arbiter that shares one 36-bit Avalon-MM memory slave (the board SDRAM/block-RAM word store).
- Requesters: two 64K core memory modules (ports 0, 1) and the console/front-panel examine-deposit engine (port 2).
- Sequences one transaction at a time, relocates each port's 16-bit word address into the 18-bit slave space, and aborts hung transactions with a watchdog.

Parameters:
- BASE_P0, 2'd0: slave address bits [17:16] applied to port 0.
- BASE_P1, 2'd1: slave address bits [17:16] applied to port 1.
- CONSOLE_PRIO, 1: 1 = port 2 has fixed priority over ports 0/1; 0 = plain 3-way round-robin.
- TIMEOUT, 16'd1000: cycles in GRANT before the watchdog aborts; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- s0_address  in  18  port 0 address; only [15:0] used
- s0_read, s0_write  in  1 each  port 0 commands
- s0_writedata  in  36  port 0 write data
- s0_readdata  out  36  port 0 read data
- s0_waitrequest  out  1  port 0 stall
- s1_* and s2_*  (same set, same widths)  ports 1 and 2; s2_address uses all 18 bits
- m_address  out  18  slave address
- m_read, m_write  out  1 each  slave commands
- m_writedata  out  36  slave write data
- m_readdata  in  36  slave read data
- m_waitrequest  in  1  slave stall
- err_timeout  out  1  sticky watchdog flag
- err_proto  out  1  sticky read-and-write-together flag
- err_clr  in  1  synchronous clear of both error flags

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE, grant none, rr pointer=2 (port 0 searched first), watchdog=0.
  - err_timeout=0, err_proto=0.
  - all sN_waitrequest=1, m_read=m_write=0, m_address=0, m_writedata=0, all sN_readdata=0.
  - Reset during GRANT drops the slave command immediately; the in-flight transaction is lost.
- Request: portN requests when sN_read|sN_write.
- IDLE:
  - All sN_waitrequest=1; m_read=m_write=0.
  - Grant selection:
    - CONSOLE_PRIO=1: port 2 wins if requesting; otherwise round-robin between ports 0 and 1.
    - CONSOLE_PRIO=0: round-robin starts at rr+1 mod 3.
  - Winner is registered at the clock edge; go to GRANT. rr is updated to the winner.
  - Minimum request-to-slave-command latency is 1 cycle.
- GRANT, owner k:
  - m_read=sk_read and not sk_write; m_write=sk_write; m_writedata=sk_writedata.
  - m_address: {BASE_Pk, sk_address[15:0]} for ports 0/1; s2_address for port 2.
  - sk_waitrequest=m_waitrequest. Non-owners keep waitrequest=1.
  - sk_readdata=m_readdata (combinational). Non-owner readdata=0.
  - Completion: at an edge where the owner is requesting and m_waitrequest=0, go to IDLE. There is at least one IDLE cycle between grants, so back-to-back service of one port is 1 transaction per (slave latency + 2) cycles.
  - Owner drops its request without completing (protocol violation): go to IDLE at the next edge; no flag.
  - sk_read and sk_write both 1: perform the write only; set err_proto.
- Watchdog:
  - Counts cycles in GRANT; cleared in IDLE.
  - Reaching TIMEOUT (when nonzero): for one cycle force m_read=m_write=0, sk_waitrequest=0, sk_readdata=0; set err_timeout; go to IDLE.
  - A normal completion in the same cycle takes precedence; no flag is set.
- err_clr: clears both flags. A set event in the same cycle wins.
- Simultaneous requests while in GRANT: wait, never preempt. Priority is evaluated only in IDLE.

Test Plan:
- Single port-0 read at s0_address=0x0123, BASE_P0=0, slave returns 36'o123456701234 after 2 wait cycles -> m_address=0x00123, s0_readdata matches on the cycle s0_waitrequest drops, state back to IDLE next edge.
- Ports 0 and 1 write continuously, CONSOLE_PRIO=1, no port 2 -> grants alternate 0,1,0,1; port 1 m_address upper bits = 2'b01; write data is forwarded unchanged.
- Port 2 requests while port 0 holds GRANT -> port 0 completes first, port 2 granted next even though port 1 is also waiting; with CONSOLE_PRIO=0, order is rr-based (after port 0: 1 then 2).
- Slave holds m_waitrequest=1 forever, TIMEOUT=8 -> after 8 GRANT cycles s0_waitrequest=0 for one cycle with readdata=0, err_timeout=1; err_clr pulse -> 0.
- s1_read=s1_write=1 -> only m_write asserted, err_proto=1; assert reset_n=0 mid-GRANT -> m_write drops asynchronously, all waitrequests=1.
